bk_operand_feeder: RTL and testbench

Byte-stream front end for the 12-bit Brent-Kung adder. It assembles three-byte frames into a 12-bit operand pair, interleaves A and B into the adder's 24-bit `INPUTS` bus order, and holds the word in a registered output slot under a valid/ready handshake. It also detects framing errors, discards malformed frames, and keeps a sticky error flag and a saturating error counter.

---
 rtl/bk_operand_feeder.sv | 116 +++++++++++
 tb/tb_bk_operand_feeder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bk_operand_feeder.sv
// Byte-stream front end for the 12-bit Brent-Kung adder: assembles 3-byte frames
// into an interleaved A/B word held in a registered valid/ready output slot.
module bk_operand_feeder #(
   parameter bit SWAP_AB = 1'b0,
   parameter int ERRW    = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      in_data,
   input  logic            in_valid,
   input  logic            in_last,
   output logic            in_ready,
   output logic [23:0]     inputs_o,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            err_o,
   output logic [ERRW-1:0] err_cnt
);

   typedef enum logic [1:0] {B0, B1, B2, FULL} state_t;

   state_t          state_q;
   logic [11:0]     opA_q;
   logic [11:0]     opB_q;
   logic [23:0]     word_q;
   logic            outValid_q;
   logic            err_q;
   logic [ERRW-1:0] errCnt_q;

   logic accept;
   logic drain;
   logic slotFree;

   // A on even bits, B on odd bits (roles exchanged when SWAP_AB is set).
   function automatic logic [23:0] interleave(input logic [11:0] a, input logic [11:0] b);
      logic [23:0] w;
      w = '0;
      for (int i = 0; i < 12; i++) begin
         w[2*i]   = SWAP_AB ? b[i] : a[i];
         w[2*i+1] = SWAP_AB ? a[i] : b[i];
      end
      return w;
   endfunction

   assign in_ready  = (state_q != FULL) && !rst;
   assign accept    = in_valid && in_ready;
   assign drain     = outValid_q && out_ready;
   assign slotFree  = !outValid_q || out_ready;
   assign inputs_o  = word_q;
   assign out_valid = outValid_q;
   assign err_o     = err_q;
   assign err_cnt   = errCnt_q;

   // Frame assembly, output slot and error bookkeeping share one state machine.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= B0;
         opA_q      <= '0;
         opB_q      <= '0;
         word_q     <= '0;
         outValid_q <= 1'b0;
         err_q      <= 1'b0;
         errCnt_q   <= '0;
      end else begin
         if (drain) begin
            outValid_q <= 1'b0;
         end
         case (state_q)
            B0: begin
               if (accept && !in_last) begin
                  opA_q[7:0] <= in_data;
                  state_q    <= B1;
               end
            end
            B1: begin
               if (accept && !in_last) begin
                  opA_q[11:8] <= in_data[3:0];
                  opB_q[3:0]  <= in_data[7:4];
                  state_q     <= B2;
               end else if (accept) begin
                  state_q <= B0;
               end
            end
            B2: begin
               if (accept && in_last && slotFree) begin
                  word_q     <= interleave(opA_q, {in_data, opB_q[3:0]});
                  outValid_q <= 1'b1;
                  state_q    <= B0;
               end else if (accept && in_last) begin
                  opB_q[11:4] <= in_data;
                  state_q     <= FULL;
               end else if (accept) begin
                  state_q <= B0;
               end
            end
            FULL: begin
               // The parked word takes over the slot on the drain edge.
               if (drain) begin
                  word_q     <= interleave(opA_q, opB_q);
                  outValid_q <= 1'b1;
                  state_q    <= B0;
               end
            end
            default: state_q <= B0;
         endcase

         if (accept && (((state_q == B0) || (state_q == B1)) ? in_last : !in_last)) begin
            err_q <= 1'b1;
            if (errCnt_q != {ERRW{1'b1}}) begin
               errCnt_q <= errCnt_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bk_operand_feeder.sv
// Directed self-checking bench for bk_operand_feeder; a second instance with
// SWAP_AB=1 sees the same stimulus.
module tb_bk_operand_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  inData;
   logic        inValid;
   logic        inLast;
   logic        outReady;
   logic        inReady;
   logic [23:0] inputsO;
   logic        outValid;
   logic        errO;
   logic [7:0]  errCnt;
   logic        inReadyS;
   logic [23:0] inputsS;
   logic        outValidS;
   logic        errS;
   logic [7:0]  errCntS;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bk_operand_feeder #(.SWAP_AB(1'b0), .ERRW(8)) dut (
      .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_last(inLast),
      .in_ready(inReady), .inputs_o(inputsO), .out_valid(outValid), .out_ready(outReady),
      .err_o(errO), .err_cnt(errCnt)
   );

   bk_operand_feeder #(.SWAP_AB(1'b1), .ERRW(8)) dutSwap (
      .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_last(inLast),
      .in_ready(inReadyS), .inputs_o(inputsS), .out_valid(outValidS), .out_ready(outReady),
      .err_o(errS), .err_cnt(errCntS)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents one byte, waits (bounded) for in_ready, then completes the handshake.
   task automatic applyStimulus(input logic [7:0] data, input logic last);
      int waitCycles;
      inData     = data;
      inLast     = last;
      inValid    = 1'b1;
      waitCycles = 0;
      while (!inReady && waitCycles < 20) begin
         step();
         waitCycles++;
      end
      checkOutput("in_ready_wait", inReady, 1'b1);
      step();
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      inData   = 8'h00;
      inValid  = 1'b0;
      inLast   = 1'b0;
      outReady = 1'b1;
      step();
      step();
      checkOutput("reset_out_valid", outValid, 1'b0);
      checkOutput("reset_inputs", inputsO, 24'h000000);
      checkOutput("reset_err", errO, 1'b0);
      checkOutput("reset_err_cnt", errCnt, 8'd0);
      checkOutput("reset_in_ready", inReady, 1'b0);
      rst = 1'b0;
      #1;
      checkOutput("post_reset_in_ready", inReady, 1'b1);

      // Basic frame: A=0xFFF, B=0x001
      applyStimulus(8'hFF, 1'b0);
      checkOutput("basic_no_early_valid", outValid, 1'b0);
      applyStimulus(8'h1F, 1'b0);
      applyStimulus(8'h00, 1'b1);
      checkOutput("basic_valid", outValid, 1'b1);
      checkOutput("basic_word", inputsO, 24'h555557);
      checkOutput("swap_word", inputsS, 24'hAAAAAB);
      step();
      checkOutput("basic_drained", outValid, 1'b0);

      // Back-pressure with a parked second word
      outReady = 1'b0;
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'hF0, 1'b0);
      applyStimulus(8'hFF, 1'b1);
      checkOutput("bp_valid", outValid, 1'b1);
      checkOutput("bp_word", inputsO, 24'hAAAAAA);
      step();
      step();
      checkOutput("bp_hold_valid", outValid, 1'b1);
      checkOutput("bp_hold_word", inputsO, 24'hAAAAAA);
      applyStimulus(8'h34, 1'b0);
      applyStimulus(8'h12, 1'b0);
      applyStimulus(8'h56, 1'b1);
      checkOutput("full_in_ready", inReady, 1'b0);
      checkOutput("full_word_held", inputsO, 24'hAAAAAA);
      step();
      checkOutput("full_still_blocked", inReady, 1'b0);
      outReady = 1'b1;
      step();
      checkOutput("drain_valid", outValid, 1'b1);
      checkOutput("drain_word", inputsO, 24'h262D12);
      checkOutput("drain_swap_word", inputsS, 24'h191E21);
      checkOutput("drain_in_ready", inReady, 1'b1);
      step();
      checkOutput("drain_empty", outValid, 1'b0);

      // Framing errors: early last, then missing last
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b1);
      checkOutput("ferr_flag", errO, 1'b1);
      checkOutput("ferr_cnt", errCnt, 8'd1);
      checkOutput("ferr_no_valid", outValid, 1'b0);
      applyStimulus(8'hFF, 1'b0);
      applyStimulus(8'h1F, 1'b0);
      applyStimulus(8'h00, 1'b1);
      checkOutput("ferr_recover_word", inputsO, 24'h555557);
      checkOutput("ferr_recover_valid", outValid, 1'b1);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'h03, 1'b0);
      checkOutput("ferr_nolast_cnt", errCnt, 8'd2);
      checkOutput("ferr_nolast_no_valid", outValid, 1'b0);

      // Reset after byte1 discards the partial frame and the error state
      applyStimulus(8'h12, 1'b0);
      applyStimulus(8'h34, 1'b0);
      rst = 1'b1;
      step();
      checkOutput("midrst_err", errO, 1'b0);
      checkOutput("midrst_cnt", errCnt, 8'd0);
      checkOutput("midrst_valid", outValid, 1'b0);
      checkOutput("midrst_inputs", inputsO, 24'h000000);
      checkOutput("midrst_in_ready", inReady, 1'b0);
      rst = 1'b0;
      #1;
      applyStimulus(8'hFF, 1'b0);
      applyStimulus(8'h1F, 1'b0);
      applyStimulus(8'h00, 1'b1);
      checkOutput("midrst_word", inputsO, 24'h555557);
      checkOutput("midrst_word_valid", outValid, 1'b1);
      checkOutput("midrst_no_err", errO, 1'b0);
      step();

      // Counter saturation with single-byte frames
      for (int i = 0; i < 300; i++) begin
         applyStimulus(i[7:0], 1'b1);
         if (i == 254) begin
            checkOutput("sat_reach_255", errCnt, 8'd255);
         end
      end
      checkOutput("sat_cnt", errCnt, 8'd255);
      checkOutput("sat_flag", errO, 1'b1);
      checkOutput("sat_no_valid", outValid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
